sc_uart_tx_io: RTL
==================

Name: sc_uart_tx_io

Overview:
- Memory-mapped UART transmitter peripheral on the single-cycle computer's data bus, in parallel with the data memory.
- Consumes the CPU's store traffic: ALU result as address, store data, write enable.
- Bytes stored to the TX address are queued in a small FIFO and serialised 8N1 on a txd pin.
- A status register is readable via the same address bus; the top-level muxes it into memout.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16
TX_ADDR, 32'hFFFF_FF00, store address that enqueues a byte
STAT_ADDR, 32'hFFFF_FF04, status read address; store here clears overflow

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
addr  in  32  bus address (CPU aluout)
datain  in  32  store data; bits [7:0] used
we  in  1  store strobe (CPU wmem), sampled on rising clock
dataout  out  32  read data, combinational from addr
txd  out  1  serial output, idle high
tx_busy  out  1  frame in progress or FIFO non-empty

Behaviour:
- Reset (async, resetn=0):
  - txd=1, tx_busy=0.
  - FIFO empty, count=0, overflow=0.
  - FSM in IDLE; baud counter and bit index = 0.
  - Applies immediately even mid-frame: the frame is aborted and queued bytes are discarded.
- Push:
  - At the rising edge with we=1 and addr==TX_ADDR: datain[7:0] is written if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same edge. In the latter case count is unchanged.
  - Otherwise the byte is dropped and sticky overflow is set to 1.
- Store to STAT_ADDR: clears overflow; data ignored.
- Other addresses: no side effects; stores to other addresses are the data memory's business.
- dataout:
  - addr==STAT_ADDR: {23'b0, count[4:0], overflow, empty, full, tx_busy} in bits [31:0].
  - addr==TX_ADDR: reads 0.
  - Otherwise: 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, go to START, baud counter=0. txd=1.
  - START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: txd=shift[0]; every CLK_DIV cycles shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Timing:
  - txd falls on the second rising edge after the enqueuing edge when the FSM is IDLE (push edge, then pop edge).
  - Frame is exactly 10*CLK_DIV cycles.
- txd is driven from a register; no glitches.
- tx_busy = (state!=IDLE) | !empty.
- FIFO wrap: read/write pointers are log2(FIFO_DEPTH) bits, wrap modulo depth; count is a separate counter.
- Simultaneous push and pop when empty: the pop sees the pre-edge empty state, so no pop. The byte is popped on the next edge.

Decomposition:
- Shared package sc_io_pkg holds:
  - TX_ADDR and STAT_ADDR constants;
  - status bit indices (ST_BUSY=0, ST_FULL=1, ST_EMPTY=2, ST_OVF=3, ST_CNT_LSB=4);
  - FSM state encoding.
- One sub-module, sc_fifo:
  - Synchronous FIFO, parameterised width 8 and depth.
  - Ports: push/pop/din/dout/full/empty/count.
  - Async active-low reset.
- The top of this block holds the address decode, the overflow flag, the baud counter and the FSM.

Test Plan:
- Reset then idle (CLK_DIV=4), 100 cycles with no stores -> txd=1 throughout, tx_busy=0, dataout at STAT_ADDR=32'h0000_0004.
- Single store 8'hA5 to TX_ADDR -> txd falls 2 edges later; bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy drops after 40 cycles.
- Five back-to-back stores 8'h01..8'h05 -> the 5th is accepted because the 1st is already popped. Frames are contiguous with stop→start and no idle gap, and overflow=0.
- Six rapid stores while frames are pending -> the 6th is dropped and status bit 3 = 1. A store to STAT_ADDR then clears it; count reads 4.
- Assert resetn=0 mid-DATA of the 2nd of 3 queued bytes -> txd=1 immediately, status = 32'h4 after release, no further frames.
- Store to addr 32'h0000_0010 with we=1 -> FIFO unchanged, dataout=0, txd stays 1.

Source files
------------

// File: rtl/sc_io_pkg.sv
// Shared definitions for the single-cycle computer's memory-mapped UART TX:
// bus addresses, status word layout and transmitter state encoding.
package sc_io_pkg;

  localparam logic [31:0] UART_TX_ADDR   = 32'hFFFF_FF00;
  localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_FF04;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic [4:0] cnt,
    input logic       ovf,
    input logic       empty,
    input logic       full,
    input logic       busy
  );
    logic [31:0] word;
    word                   = 32'h0000_0000;
    word[ST_CNT_LSB +: 5]  = cnt;
    word[ST_OVF]           = ovf;
    word[ST_EMPTY]         = empty;
    word[ST_FULL]          = full;
    word[ST_BUSY]          = busy;
    return word;
  endfunction

endpackage

// File: rtl/sc_fifo.sv
// Small synchronous FIFO with a separate occupancy counter; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sc_uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue bytes, the
// status word is readable at STAT_ADDR and a store there clears overflow.
module sc_uart_tx_io
  import sc_io_pkg::*;
#(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TX_ADDR    = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  output logic [31:0] dataout,
  output logic        txd,
  output logic        tx_busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  tx_state_e     state;
  tx_state_e     state_next;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          txd_next;
  logic          baud_end;
  logic          overflow;
  logic          push_req;
  logic          stat_wr;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [4:0]    count5;
  logic [23:0]   unused_datain;

  assign push_req      = we & (addr == TX_ADDR);
  assign stat_wr       = we & (addr == STAT_ADDR);
  assign baud_end      = (baud_cnt == BAUD_LAST);
  assign count5        = 5'(fifo_count);
  assign unused_datain = datain[31:8];

  sc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_req),
    .pop    (pop),
    .din    (datain[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign tx_busy = (state != TX_IDLE) | ~fifo_empty;
  assign dataout = (addr == STAT_ADDR)
                 ? pack_status(count5, overflow, fifo_empty, fifo_full, tx_busy)
                 : 32'h0000_0000;

  // A full FIFO still takes the byte when the transmitter pops on the same edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (stat_wr) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= TX_IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      txd      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      txd      <= txd_next;
    end
  end

  // txd_next is the line level for the cycle after the edge, keeping txd registered.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    txd_next      = txd;
    pop           = 1'b0;
    case (state)
      TX_IDLE: begin
        baud_cnt_next = 16'd0;
        bit_idx_next  = 3'd0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          state_next = TX_START;
          txd_next   = 1'b0;
        end else begin
          txd_next = 1'b1;
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_cnt_next = 16'd0;
          bit_idx_next  = 3'd0;
          state_next    = TX_DATA;
          txd_next      = shift[0];
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_cnt_next = 16'd0;
          if (bit_idx == 3'd7) begin
            state_next = TX_STOP;
            txd_next   = 1'b1;
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            bit_idx_next = bit_idx + 3'd1;
            txd_next     = shift[1];
          end
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_cnt_next = 16'd0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = TX_START;
            txd_next   = 1'b0;
          end else begin
            state_next = TX_IDLE;
            txd_next   = 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_next    = TX_IDLE;
        baud_cnt_next = 16'd0;
        bit_idx_next  = 3'd0;
        txd_next      = 1'b1;
      end
    endcase
  end

endmodule
